ram_bb_loader: RTL and testbench
================================

Name: ram_bb_loader

Overview:
- Write-side front end for the per-channel code (CA) and message (MSG) bit RAMs.
- Accepts the 32-bit word stream from the USB3 slave-FIFO interface and parses it into framed commands.
- Drives the shared write data, the one-hot 16-bit write-enable bus and the CA/MSG write addresses that fill the RAMs.
- Also holds the eight per-channel code-delay registers consumed by the 1.023 MHz readers.

Parameters:
- SYNC, 8'hA5, header sync byte (header[31:24]).
- N_CH, 8, number of channels.
- CA_WORDS, 32, payload words per CA frame (1023 code bits packed LSB-first, 1 pad bit).
- MSG_WORDS, 47, payload words per MSG frame (1500 bits, 4 pad bits).
- DELAY_W, 10, delay register width.
- DELAY_MAX, 1022, largest legal delay; larger values saturate to it.

Ports:
- clk  in  1  system/USB-side clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  32  stream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word; a word transfers when in_valid && in_ready.
- data  out  32  RAM write data, registered.
- wren  out  16  one-hot RAM write enable: bits 0..7 are CA ch0..7, bits 8..15 are MSG ch0..7.
- wraddress_ca  out  5  CA word address.
- wraddress_msg  out  6  MSG word address.
- delay_ca  out  N_CH*DELAY_W  packed delays; channel k occupies [k*10+9 : k*10].
- frame_done  out  1  one-cycle pulse when a valid frame completes.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_cnt  out  8  saturating count of rejected frames and discarded non-sync words.

Behaviour:
- Header word fields:
  - [31:24] = SYNC.
  - [23:20] = type: 0 = CA, 1 = MSG, 2 = DELAY, other values illegal.
  - [19:16] = channel; values >= N_CH are illegal.
  - [15:0] = LEN, count of payload words that follow.
- Legal frames are CA with LEN = CA_WORDS, MSG with LEN = MSG_WORDS, and DELAY with LEN = 1.
- States:
  - HUNT: in_ready = 1. Header with a bad sync byte: word dropped, err_cnt += 1, stay in HUNT. Legal header: latch type/channel, clear the word counter, go to LOAD. Header with sync OK but illegal type/channel/LEN: frame_err pulses, err_cnt += 1; go to DISCARD with remaining = LEN, or stay in HUNT if LEN = 0.
  - LOAD: in_ready = 1. Each accepted word is a payload word. After the last payload word, go to DONE.
  - DISCARD: in_ready = 1. Each accepted word decrements remaining; no wren. When remaining reaches 0, go to HUNT.
  - DONE: in_ready = 0 for exactly one cycle, then go to HUNT.
- Payload latency: a word accepted in cycle n produces registered outputs in cycle n+1:
  - data = word.
  - wraddress_ca = idx[4:0] and wraddress_msg = idx[5:0], where idx is the payload index starting at 0.
  - wren has exactly one bit set (type*8 + channel), high for that single cycle.
- A gap in in_valid during LOAD gives wren = 0 in the corresponding cycle; no other state changes.
- DELAY payload: the delay_ca slice for the channel takes min(word[9:0], DELAY_MAX) in cycle n+1; word[31:10] is ignored; wren stays 0.
- frame_done pulses in the same cycle as the last wren (or the delay update).
- wren is 0 in all states except the cycle after an accepted LOAD word of a CA or MSG frame.
- Addresses hold their last value between frames and restart at 0 on each legal header.
- err_cnt saturates at 255.
- Reset, applied anytime including mid-frame, in the same cycle sets:
  - state = HUNT, in_ready = 0 while rst = 1.
  - data = 0, wren = 0, both addresses = 0.
  - all delays = 0, frame_done = frame_err = 0, err_cnt = 0.
  - A partially loaded RAM is left as written; the host must resend the frame.

Decomposition:
- Shared package ram_bb_pkg holds:
  - SYNC, CA_WORDS, MSG_WORDS, DELAY_MAX.
  - Frame-type codes TYPE_CA/TYPE_MSG/TYPE_DELAY.
  - Header field bit positions.
  - The loader state enum (HUNT/LOAD/DISCARD/DONE).
- One sub-module, ram_bb_hdr_check: a combinational header decode/legality check returning type, channel, LEN and a legal flag. Everything else stays flat.

Test Plan:
- CA frame: header 32'hA5030020 (CA, ch3, LEN = 32) then words 0x1000+i with in_valid held high → wren = 16'h0008 for 32 consecutive cycles, wraddress_ca = 0..31, data = 0x1000..0x101F, frame_done coincides with the last wren, in_ready = 0 for one cycle after.
- MSG frame: header 32'hA511002F (MSG, ch1, LEN = 47) with in_valid low every 3rd cycle → wren = 16'h0200 only on accepted words, wraddress_msg = 0..46, exactly 47 writes.
- DELAY: header 32'hA5250001 (ch5) then payload 0x000003FF → delay_ca[59:50] = 1022, other slices unchanged, wren = 0, frame_done = 1.
- Errors:
  - 32'h12345678 in HUNT → dropped, err_cnt = 1.
  - Header 32'hA5000010 (CA, LEN = 16) → frame_err, 16 words swallowed with no wren, err_cnt = 2.
  - A following legal frame then loads normally.
- Reset after the 10th payload word of a CA ch0 frame → next cycle wren = 0, addresses = 0, state HUNT, delays = 0; a fresh frame loads from address 0.

Source files
------------

// File: rtl/ram_bb_pkg.sv
// Shared constants, header field positions and loader state encoding for the
// CA/MSG bit-RAM write front end.
package ram_bb_pkg;

    localparam logic [7:0]  SYNC      = 8'hA5;
    localparam int          N_CH      = 8;
    localparam int          DELAY_W   = 10;
    localparam logic [15:0] CA_WORDS  = 16'd32;
    localparam logic [15:0] MSG_WORDS = 16'd47;
    localparam logic [9:0]  DELAY_MAX = 10'd1022;

    localparam logic [1:0] TYPE_CA    = 2'd0;
    localparam logic [1:0] TYPE_MSG   = 2'd1;
    localparam logic [1:0] TYPE_DELAY = 2'd2;

    localparam int SYNC_HI = 31;
    localparam int SYNC_LO = 24;
    localparam int TYPE_HI = 23;
    localparam int TYPE_LO = 20;
    localparam int CH_HI   = 19;
    localparam int CH_LO   = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOAD    = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } loader_state_e;

    function automatic logic [9:0] sat_delay(input logic [9:0] v);
        return (v > DELAY_MAX) ? DELAY_MAX : v;
    endfunction

endpackage

// File: rtl/ram_bb_hdr_check.sv
// Combinational header decode: splits the word into fields and flags whether
// it describes one of the three legal frame shapes.
module ram_bb_hdr_check
    import ram_bb_pkg::*;
(
    input  logic [31:0] hdr,
    output logic        sync_ok,
    output logic [1:0]  typ,
    output logic [2:0]  ch,
    output logic [15:0] len,
    output logic        legal
);

    logic [3:0] typ_f;
    logic [3:0] ch_f;
    logic       len_ok;

    always_comb begin
        typ_f   = hdr[TYPE_HI:TYPE_LO];
        ch_f    = hdr[CH_HI:CH_LO];
        len     = hdr[LEN_HI:LEN_LO];
        typ     = typ_f[1:0];
        ch      = ch_f[2:0];
        sync_ok = (hdr[SYNC_HI:SYNC_LO] == SYNC);
        len_ok  = 1'b0;
        case (typ_f[1:0])
            TYPE_CA:    len_ok = (len == CA_WORDS);
            TYPE_MSG:   len_ok = (len == MSG_WORDS);
            TYPE_DELAY: len_ok = (len == 16'd1);
            default:    len_ok = 1'b0;
        endcase
        legal = sync_ok && (typ_f[3:2] == 2'b00) && (ch_f < 4'(N_CH)) && len_ok;
    end

endmodule

// File: rtl/ram_bb_loader.sv
// Parses the USB3 slave-FIFO word stream into CA/MSG RAM writes and per-channel
// code-delay updates; malformed input is counted and skipped.
module ram_bb_loader
    import ram_bb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               data,
    output logic [15:0]               wren,
    output logic [4:0]                wraddress_ca,
    output logic [5:0]                wraddress_msg,
    output logic [N_CH*DELAY_W-1:0]   delay_ca,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic [7:0]                err_cnt,
    output loader_state_e             state_dbg
);

    // Handshake: a word moves when in_valid && in_ready in the same cycle;
    // in_valid may drop at any time, in_ready is low in DONE and during reset.

    loader_state_e state;
    logic [1:0]    cur_type;
    logic [2:0]    cur_ch;
    logic [5:0]    idx;
    logic [5:0]    last_idx;
    logic [15:0]   remaining;
    logic          accept;

    logic          hdr_sync_ok;
    logic [1:0]    hdr_type;
    logic [2:0]    hdr_ch;
    logic [15:0]   hdr_len;
    logic          hdr_legal;

    ram_bb_hdr_check u_hdr_check (
        .hdr     (in_data),
        .sync_ok (hdr_sync_ok),
        .typ     (hdr_type),
        .ch      (hdr_ch),
        .len     (hdr_len),
        .legal   (hdr_legal)
    );

    assign in_ready  = !rst && (state != DONE);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;
    assign last_idx  = (cur_type == TYPE_MSG) ? 6'(MSG_WORDS - 16'd1) : 6'(CA_WORDS - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            cur_type      <= TYPE_CA;
            cur_ch        <= '0;
            idx           <= '0;
            remaining     <= '0;
            data          <= '0;
            wren          <= '0;
            wraddress_ca  <= '0;
            wraddress_msg <= '0;
            delay_ca      <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            wren       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept) begin
                        if (!hdr_sync_ok) begin
                            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        end else if (hdr_legal) begin
                            cur_type      <= hdr_type;
                            cur_ch        <= hdr_ch;
                            idx           <= '0;
                            wraddress_ca  <= '0;
                            wraddress_msg <= '0;
                            state         <= LOAD;
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                            if (hdr_len != 16'd0) begin
                                remaining <= hdr_len;
                                state     <= DISCARD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        data <= in_data;
                        if (cur_type == TYPE_DELAY) begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (cur_ch == 3'(k))
                                    delay_ca[k*DELAY_W +: DELAY_W] <= sat_delay(in_data[9:0]);
                            end
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            // MSG enables sit 8 bits above the CA enables.
                            wren          <= 16'd1 << {cur_type[0], cur_ch};
                            wraddress_ca  <= idx[4:0];
                            wraddress_msg <= idx;
                            idx           <= idx + 6'd1;
                            if (idx == last_idx) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= HUNT;
                    end
                end
                DONE: begin
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bb_loader.sv
// Directed bench for ram_bb_loader: vector table for error/delay handling plus
// hand-written CA, MSG and mid-frame reset sequences.
module tb_ram_bb_loader;
    import ram_bb_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             data;
    logic [15:0]             wren;
    logic [4:0]              wraddress_ca;
    logic [5:0]              wraddress_msg;
    logic [N_CH*DELAY_W-1:0] delay_ca;
    logic                    frame_done;
    logic                    frame_err;
    logic [7:0]              err_cnt;
    loader_state_e           state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    typedef struct {
        logic [31:0]   din;
        logic          vld;
        logic [15:0]   exp_wren;
        logic          exp_done;
        logic          exp_ferr;
        logic [7:0]    exp_errc;
        loader_state_e exp_st;
        logic          exp_rdy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ram_bb_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data          (data),
        .wren          (wren),
        .wraddress_ca  (wraddress_ca),
        .wraddress_msg (wraddress_msg),
        .delay_ca      (delay_ca),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_cnt       (err_cnt),
        .state_dbg     (state_dbg)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge that consumed the driven word.
    task automatic drive(input logic [31:0] w, input logic v);
        in_data  = w;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] din, input logic vld, input logic [15:0] ew,
                           input logic ed, input logic ef, input logic [7:0] ec,
                           input loader_state_e es, input logic er);
        vec_t v;
        v.din = din; v.vld = vld; v.exp_wren = ew; v.exp_done = ed;
        v.exp_ferr = ef; v.exp_errc = ec; v.exp_st = es; v.exp_rdy = er;
        vecs.push_back(v);
    endtask

    task automatic run_ca(input string tag, input logic [31:0] hdr, input logic [15:0] exp_w,
                          input logic [31:0] base);
        drive(hdr, 1'b1);
        chk({tag, " hdr state"}, 80'(state_dbg), 80'(LOAD));
        chk({tag, " hdr wren"}, 80'(wren), 80'h0);
        for (int i = 0; i < 32; i++) begin
            drive(base + 32'(i), 1'b1);
            chk($sformatf("%s wren%0d", tag, i), 80'(wren), 80'(exp_w));
            chk($sformatf("%s addr%0d", tag, i), 80'(wraddress_ca), 80'(i));
            chk($sformatf("%s data%0d", tag, i), 80'(data), 80'(base + 32'(i)));
            chk($sformatf("%s done%0d", tag, i), 80'(frame_done), 80'(i == 31));
        end
        chk({tag, " ready after"}, 80'(in_ready), 80'h0);
        drive(32'h0, 1'b0);
        chk({tag, " ready back"}, 80'(in_ready), 80'h1);
        chk({tag, " state back"}, 80'(state_dbg), 80'(HUNT));
    endtask

    initial begin
        logic [79:0] exp_delay;
        logic [37:0] e;
        int n, cyc, wr_cnt;

        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        #1;
        chk("ready in reset", 80'(in_ready), 80'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst state", 80'(state_dbg), 80'(HUNT));
        chk("rst wren", 80'(wren), 80'h0);
        chk("rst data", 80'(data), 80'h0);
        chk("rst errcnt", 80'(err_cnt), 80'h0);
        chk("rst delay", delay_ca, 80'h0);
        rst = 1'b0;
        #1;
        chk("ready after rst", 80'(in_ready), 80'h1);

        add_vec(32'h12345678, 1'b1, 16'h0, 1'b0, 1'b0, 8'd1, HUNT, 1'b1);
        add_vec(32'hA5000010, 1'b1, 16'h0, 1'b0, 1'b1, 8'd2, DISCARD, 1'b1);
        for (int i = 0; i < 16; i++)
            add_vec(32'hA5000020 + 32'(i), 1'b1, 16'h0, 1'b0, 1'b0, 8'd2,
                    (i == 15) ? HUNT : DISCARD, 1'b1);
        add_vec(32'hA5250001, 1'b1, 16'h0, 1'b0, 1'b0, 8'd2, LOAD, 1'b1);
        add_vec(32'h000003FF, 1'b1, 16'h0, 1'b1, 1'b0, 8'd2, DONE, 1'b0);
        add_vec(32'h00000000, 1'b0, 16'h0, 1'b0, 1'b0, 8'd2, HUNT, 1'b1);
        add_vec(32'hA5220001, 1'b1, 16'h0, 1'b0, 1'b0, 8'd2, LOAD, 1'b1);
        add_vec(32'hFFFFFC05, 1'b1, 16'h0, 1'b1, 1'b0, 8'd2, DONE, 1'b0);
        add_vec(32'h00000000, 1'b0, 16'h0, 1'b0, 1'b0, 8'd2, HUNT, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].din, vecs[i].vld);
            chk($sformatf("vec%0d wren", i), 80'(wren), 80'(vecs[i].exp_wren));
            chk($sformatf("vec%0d done", i), 80'(frame_done), 80'(vecs[i].exp_done));
            chk($sformatf("vec%0d ferr", i), 80'(frame_err), 80'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d errcnt", i), 80'(err_cnt), 80'(vecs[i].exp_errc));
            chk($sformatf("vec%0d state", i), 80'(state_dbg), 80'(vecs[i].exp_st));
            chk($sformatf("vec%0d ready", i), 80'(in_ready), 80'(vecs[i].exp_rdy));
        end
        exp_delay = (80'd1022 << 50) | (80'd5 << 20);
        chk("delay_ca", delay_ca, exp_delay);

        run_ca("ca3", 32'hA5030020, 16'h0008, 32'h00001000);
        chk("errcnt kept", 80'(err_cnt), 80'd2);

        drive(32'hA511002F, 1'b1);
        chk("msg hdr state", 80'(state_dbg), 80'(LOAD));
        n = 0; cyc = 0; wr_cnt = 0;
        while (n < 47 && cyc < 200) begin
            if ((cyc % 3) != 2) begin
                exp_q.push_back({6'(n), 32'h2000 + 32'(n)});
                drive(32'h2000 + 32'(n), 1'b1);
                if (wren != 16'h0) wr_cnt++;
                chk($sformatf("msg wren%0d", n), 80'(wren), 80'h0200);
                e = exp_q.pop_front();
                chk($sformatf("msg addr%0d", n), 80'(wraddress_msg), 80'(e[37:32]));
                chk($sformatf("msg data%0d", n), 80'(data), 80'(e[31:0]));
                chk($sformatf("msg done%0d", n), 80'(frame_done), 80'(n == 46));
                n++;
            end else begin
                drive(32'hFFFFFFFF, 1'b0);
                if (wren != 16'h0) wr_cnt++;
                chk($sformatf("msg gap%0d", cyc), 80'(wren), 80'h0);
            end
            cyc++;
        end
        chk("msg writes", 80'(wr_cnt), 80'd47);
        chk("msg ready after", 80'(in_ready), 80'h0);
        drive(32'h0, 1'b0);
        chk("msg state back", 80'(state_dbg), 80'(HUNT));

        drive(32'hA5000020, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(32'h3000 + 32'(i), 1'b1);
            chk($sformatf("part addr%0d", i), 80'(wraddress_ca), 80'(i));
        end
        rst = 1'b1;
        in_data = 32'h300A;
        in_valid = 1'b1;
        #1;
        chk("ready mid rst", 80'(in_ready), 80'h0);
        @(posedge clk);
        #1;
        chk("mrst wren", 80'(wren), 80'h0);
        chk("mrst addr ca", 80'(wraddress_ca), 80'h0);
        chk("mrst addr msg", 80'(wraddress_msg), 80'h0);
        chk("mrst state", 80'(state_dbg), 80'(HUNT));
        chk("mrst delay", delay_ca, 80'h0);
        chk("mrst data", 80'(data), 80'h0);
        chk("mrst errcnt", 80'(err_cnt), 80'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        run_ca("ca0", 32'hA5000020, 16'h0001, 32'h00004000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
